// File: rtl/lpif_rx_pkg.sv
// Shared framing constants, parser state and per-byte marker types for the LPIF RX framing decoder.
// Pure declarations; no timing or flow-control behaviour lives here.
package lpif_rx_pkg;

   localparam logic [7:0] STP_K  = 8'hFB;
   localparam logic [7:0] SDP_K  = 8'h5C;
   localparam logic [7:0] END_K  = 8'hFD;
   localparam logic [7:0] EDB_K  = 8'hFE;

   localparam logic [7:0] SDP_B0 = 8'hF0;
   localparam logic [7:0] SDP_B1 = 8'hAC;
   localparam logic [7:0] EDB_B  = 8'hC0;
   localparam logic [7:0] IDL_B  = 8'h00;

   localparam logic [2:0] GEN1   = 3'd1;
   localparam logic [2:0] GEN5   = 3'd5;

   localparam int CNT_W = 13;

   typedef enum logic [1:0] {S_IDLE, S_TOK, S_TLP, S_DLLP} st_e;
   typedef enum logic [1:0] {T_STP, T_SDP, T_EDB} tok_e;

   // ended: last Gen5 byte closed a TLP, so a following 0xC0 starts an EDB token
   typedef struct packed {
      st_e              st;
      tok_e             tok;
      logic [CNT_W-1:0] cnt;
      logic [3:0]       nib;
      logic             first;
      logic             ended;
   } pstate_t;

   localparam pstate_t PSTATE_RST = '0;

   typedef struct packed {
      logic tlpstart;
      logic tlpend;
      logic dllpstart;
      logic dllpend;
      logic edb;
   } mk_t;

endpackage

// File: rtl/lpif_rx_byte_parser.sv
// One-byte combinational framing step; chained NBYTES deep by the top, zero latency.
// No flow control: the caller gates every output with its own cycle-valid.
module lpif_rx_byte_parser
   import lpif_rx_pkg::*;
#(
   parameter int DLLP_LEN = 6
) (
   input  pstate_t    i_st,
   input  logic [7:0] i_byte,
   input  logic       i_k,
   input  logic [2:0] i_gen,
   output pstate_t    o_st,
   output logic       o_vld,
   output mk_t        o_mk,
   output logic       o_lb_tlpend,
   output logic       o_lb_edb,
   output logic       o_err
);

   logic [10:0]      w_len;
   logic [CNT_W-1:0] w_tlp_cnt;

   assign w_len     = {i_byte[6:0], i_st.nib};
   assign w_tlp_cnt = {w_len, 2'b00} - CNT_W'(2);

   always_comb begin
      o_st        = i_st;
      o_vld       = 1'b0;
      o_mk        = '0;
      o_lb_tlpend = 1'b0;
      o_lb_edb    = 1'b0;
      o_err       = 1'b0;
      if (i_gen == GEN1) begin
         case (i_st.st)
            S_IDLE: begin
               if (i_k && i_byte == STP_K) begin
                  o_st.st    = S_TLP;
                  o_st.first = 1'b1;
               end else if (i_k && i_byte == SDP_K) begin
                  o_st.st    = S_DLLP;
                  o_st.first = 1'b1;
                  o_st.cnt   = CNT_W'(DLLP_LEN);
               end
            end
            S_TLP: begin
               if (i_k) begin
                  // END/EDB/unknown K all close the TLP on the byte before this one
                  o_st        = PSTATE_RST;
                  o_lb_tlpend = 1'b1;
                  o_lb_edb    = (i_byte != END_K);
                  o_err       = (i_byte != END_K) && (i_byte != EDB_K);
               end else begin
                  o_vld         = 1'b1;
                  o_mk.tlpstart = i_st.first;
                  o_st.first    = 1'b0;
               end
            end
            S_DLLP: begin
               if (i_st.cnt != '0) begin
                  o_vld          = 1'b1;
                  o_mk.dllpstart = i_st.first;
                  o_mk.dllpend   = (i_st.cnt == CNT_W'(1));
                  o_st.first     = 1'b0;
                  o_st.cnt       = i_st.cnt - CNT_W'(1);
               end else begin
                  o_st  = PSTATE_RST;
                  o_err = !(i_k && i_byte == END_K);
               end
            end
            default: o_st = PSTATE_RST;
         endcase
      end else if (i_gen == GEN5) begin
         case (i_st.st)
            S_IDLE: begin
               o_st.ended = 1'b0;
               if (i_st.ended && i_byte == EDB_B) begin
                  o_st.st  = S_TOK;
                  o_st.tok = T_EDB;
                  o_st.cnt = CNT_W'(3);
                  o_lb_edb = 1'b1;
               end else if (i_byte[3:0] == 4'hF) begin
                  o_st.st  = S_TOK;
                  o_st.tok = T_STP;
                  o_st.nib = i_byte[7:4];
               end else if (i_byte == SDP_B0) begin
                  o_st.st  = S_TOK;
                  o_st.tok = T_SDP;
               end else if (i_byte != IDL_B) begin
                  o_err = 1'b1;
               end
            end
            S_TOK: begin
               o_st = PSTATE_RST;
               case (i_st.tok)
                  T_STP: begin
                     if (w_len < 11'd5) begin
                        o_err = 1'b1;
                     end else begin
                        o_st.st    = S_TLP;
                        o_st.first = 1'b1;
                        o_st.cnt   = w_tlp_cnt;
                     end
                  end
                  T_SDP: begin
                     if (i_byte == SDP_B1) begin
                        o_st.st    = S_DLLP;
                        o_st.first = 1'b1;
                        o_st.cnt   = CNT_W'(DLLP_LEN);
                     end else begin
                        o_err = 1'b1;
                     end
                  end
                  default: begin
                     if (i_byte != EDB_B) begin
                        o_err = 1'b1;
                     end else if (i_st.cnt != CNT_W'(1)) begin
                        o_st.st  = S_TOK;
                        o_st.tok = T_EDB;
                        o_st.cnt = i_st.cnt - CNT_W'(1);
                     end
                  end
               endcase
            end
            S_TLP: begin
               o_vld         = 1'b1;
               o_mk.tlpstart = i_st.first;
               o_st.first    = 1'b0;
               o_st.cnt      = i_st.cnt - CNT_W'(1);
               if (i_st.cnt == CNT_W'(1)) begin
                  o_mk.tlpend = 1'b1;
                  o_st        = PSTATE_RST;
                  o_st.ended  = 1'b1;
               end
            end
            default: begin
               o_vld          = 1'b1;
               o_mk.dllpstart = i_st.first;
               o_st.first     = 1'b0;
               o_st.cnt       = i_st.cnt - CNT_W'(1);
               if (i_st.cnt == CNT_W'(1)) begin
                  o_mk.dllpend = 1'b1;
                  o_st         = PSTATE_RST;
               end
            end
         endcase
      end else begin
         o_st = PSTATE_RST;
      end
   end

endmodule

// File: rtl/lpif_rx_framing_decoder.sv
// Scans NBYTES framed RX bytes per cycle into per-byte valid/markers; 2-cycle latency.
// No backpressure: every in_valid cycle is consumed, idle cycles hold the parse state.
module lpif_rx_framing_decoder
   import lpif_rx_pkg::*;
#(
   parameter int NBYTES   = 64,
   parameter int DLLP_LEN = 6
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [2:0]          i_gen,
   input  logic                i_valid,
   input  logic [8*NBYTES-1:0] i_data,
   input  logic [NBYTES-1:0]   i_datak,
   input  logic                i_os_block,
   output logic [NBYTES-1:0]   o_packet_valid,
   output logic [8*NBYTES-1:0] o_packet_data,
   output logic [NBYTES-1:0]   o_tlpstart,
   output logic [NBYTES-1:0]   o_tlpend,
   output logic [NBYTES-1:0]   o_dllpstart,
   output logic [NBYTES-1:0]   o_dllpend,
   output logic [NBYTES-1:0]   o_edb,
   output logic                o_framing_err
);

   pstate_t             r_st;
   logic [2:0]          r_gen;
   logic                r_prev_vld;
   pstate_t             w_st [NBYTES+1];
   pstate_t             w_st0;
   pstate_t             w_st_nxt;
   logic                w_os;
   logic                w_os_err;
   logic                w_scan;
   logic                w_xlb_t;
   logic                w_xlb_e;
   logic                w_err;
   logic [NBYTES-1:0]   w_pv, w_ts, w_te, w_ds, w_de, w_eb, w_lbt, w_lbe, w_perr;

   logic [NBYTES-1:0]   r_d_pv, r_d_ts, r_d_te, r_d_ds, r_d_de, r_d_eb;
   logic [8*NBYTES-1:0] r_d_dat;
   logic                r_d_err;
   logic [NBYTES-1:0]   r_s_pv, r_s_ts, r_s_te, r_s_ds, r_s_de, r_s_eb;
   logic [8*NBYTES-1:0] r_s_dat;
   logic                r_s_err;

   // A GEN switch abandons whatever packet was in flight
   assign w_st0    = (i_gen != r_gen) ? PSTATE_RST : r_st;
   assign w_os     = i_valid && i_os_block && (i_gen == GEN5);
   assign w_os_err = w_os && (w_st0.st == S_TLP || w_st0.st == S_DLLP);
   assign w_scan   = i_valid && !w_os;
   assign w_st[0]  = w_st0;

   for (genvar g = 0; g < NBYTES; g++) begin : g_byte
      mk_t  w_mk;
      logic w_v, w_lt, w_le, w_e;
      lpif_rx_byte_parser #(.DLLP_LEN(DLLP_LEN)) u_parser (
         .i_st        (w_st[g]),
         .i_byte      (i_data[8*g +: 8]),
         .i_k         (i_datak[g]),
         .i_gen       (i_gen),
         .o_st        (w_st[g+1]),
         .o_vld       (w_v),
         .o_mk        (w_mk),
         .o_lb_tlpend (w_lt),
         .o_lb_edb    (w_le),
         .o_err       (w_e)
      );
      assign w_pv[g]   = w_v && w_scan;
      assign w_ts[g]   = w_mk.tlpstart && w_scan;
      assign w_te[g]   = w_mk.tlpend && w_scan;
      assign w_ds[g]   = w_mk.dllpstart && w_scan;
      assign w_de[g]   = w_mk.dllpend && w_scan;
      assign w_eb[g]   = w_mk.edb && w_scan;
      assign w_lbt[g]  = w_lt && w_scan;
      assign w_lbe[g]  = w_le && w_scan;
      assign w_perr[g] = w_e && w_scan;
   end

   // Byte-0 lookback lands on the previous cycle's last byte as it moves into the stage reg
   assign w_xlb_t = w_lbt[0] && r_prev_vld;
   assign w_xlb_e = w_lbe[0] && r_prev_vld;
   assign w_err   = (|w_perr) || w_os_err || ((w_lbt[0] || w_lbe[0]) && !r_prev_vld);

   always_comb begin
      w_st_nxt = w_st0;
      if (w_scan) begin
         w_st_nxt = w_st[NBYTES];
      end else if (w_os_err) begin
         w_st_nxt = PSTATE_RST;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_st       <= PSTATE_RST;
         r_gen      <= '0;
         r_prev_vld <= 1'b0;
         r_d_pv     <= '0;
         r_d_ts     <= '0;
         r_d_te     <= '0;
         r_d_ds     <= '0;
         r_d_de     <= '0;
         r_d_eb     <= '0;
         r_d_dat    <= '0;
         r_d_err    <= 1'b0;
         r_s_pv     <= '0;
         r_s_ts     <= '0;
         r_s_te     <= '0;
         r_s_ds     <= '0;
         r_s_de     <= '0;
         r_s_eb     <= '0;
         r_s_dat    <= '0;
         r_s_err    <= 1'b0;
      end else begin
         r_st       <= w_st_nxt;
         r_gen      <= i_gen;
         r_prev_vld <= i_valid;
         r_d_pv     <= w_pv;
         r_d_ts     <= w_ts;
         r_d_te     <= w_te | (w_lbt >> 1);
         r_d_ds     <= w_ds;
         r_d_de     <= w_de;
         r_d_eb     <= w_eb | (w_lbe >> 1);
         r_d_dat    <= w_scan ? i_data : '0;
         r_d_err    <= w_err;
         r_s_pv     <= r_d_pv;
         r_s_ts     <= r_d_ts;
         r_s_te     <= r_d_te | {w_xlb_t, {(NBYTES-1){1'b0}}};
         r_s_ds     <= r_d_ds;
         r_s_de     <= r_d_de;
         r_s_eb     <= r_d_eb | {w_xlb_e, {(NBYTES-1){1'b0}}};
         r_s_dat    <= r_d_dat;
         r_s_err    <= r_d_err;
      end
   end

   assign o_packet_valid = r_s_pv;
   assign o_packet_data  = r_s_dat;
   assign o_tlpstart     = r_s_ts;
   assign o_tlpend       = r_s_te;
   assign o_dllpstart    = r_s_ds;
   assign o_dllpend      = r_s_de;
   assign o_edb          = r_s_eb;
   assign o_framing_err  = r_s_err;

endmodule
